// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between pipeline
// writeback (WB) and a long-latency unit (LU). LU results are queued in a
// small FIFO and drained on idle WB cycles, or forced in by stalling WB once
// the FIFO head has waited STARVE_MAX cycles. A pending-destination
// scoreboard drives the decode busy flags.
// Optional feature macro: RF_ARB_BYPASS_EN (LU result written straight
// through when the FIFO is empty and WB is idle).
module rf_write_arbiter #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            wb_we_i,
  input  logic [AW-1:0]   wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            lu_valid_i,
  output logic            lu_ready_o,
  input  logic [AW-1:0]   lu_rd_i,
  input  logic [XLEN-1:0] lu_data_i,
  input  logic            iss_valid_i,
  input  logic [AW-1:0]   iss_rd_i,
  input  logic [AW-1:0]   qa1_i,
  input  logic [AW-1:0]   qa2_i,
  output logic            busy1_o,
  output logic            busy2_o,
  output logic            wb_stall_o,
  output logic            rf_we_o,
  output logic [AW-1:0]   rf_a3_o,
  output logic [XLEN-1:0] rf_wd_o
);

  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SW   = $clog2(STARVE_MAX + 1);
  localparam int NREG = 1 << AW;
  localparam logic [PW:0]   FULL_CNT   = (PW+1)'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  // FIFO storage (data path, never reset) and control state
  logic [AW-1:0]   mem_rd_q   [FIFO_DEPTH];
  logic [XLEN-1:0] mem_data_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [NREG-1:0] pending_q, pending_d;

  logic            empty, full, stall, pop, push, bypass;
  logic            we;
  logic [AW-1:0]   a3;
  logic [XLEN-1:0] wd;
  logic [AW-1:0]   head_rd;
  logic [XLEN-1:0] head_data;

  // Saturating increment of the starvation counter
  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == STARVE_TOP) ? v : v + SW'(1);
  endfunction

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == FULL_CNT);
  assign head_rd   = mem_rd_q[rd_ptr_q];
  assign head_data = mem_data_q[rd_ptr_q];
  assign stall     = !empty && (starve_q == STARVE_TOP);

  // Write-port grant: starved FIFO head, then WB, then FIFO head, then bypass
  always_comb begin
    pop    = 1'b0;
    bypass = 1'b0;
    we     = 1'b0;
    a3     = '0;
    wd     = '0;
    if (stall) begin
      pop = 1'b1;
      we  = (head_rd != '0);
      a3  = head_rd;
      wd  = head_data;
    end else if (wb_we_i && (wb_rd_i != '0)) begin
      we = 1'b1;
      a3 = wb_rd_i;
      wd = wb_data_i;
    end else if (!empty) begin
      pop = 1'b1;
      we  = (head_rd != '0);
      a3  = head_rd;
      wd  = head_data;
`ifdef RF_ARB_BYPASS_EN
    end else if (lu_valid_i) begin
      bypass = 1'b1;
      we     = (lu_rd_i != '0);
      a3     = lu_rd_i;
      wd     = lu_data_i;
`endif
    end
  end

  assign push = lu_valid_i && !full && !bypass && !reset_i;

  // Next-state for FIFO pointers, starvation counter and pending scoreboard
  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d     = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    starve_d  = (empty || pop) ? '0 : sat_inc(starve_q);
    pending_d = pending_q;
    if (pop && (head_rd != '0))
      pending_d[head_rd] = 1'b0;
    if (bypass && (lu_rd_i != '0))
      pending_d[lu_rd_i] = 1'b0;
    // A same-cycle issue to a register being retired keeps it pending
    if (iss_valid_i && (iss_rd_i != '0))
      pending_d[iss_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Control state update with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      starve_q  <= '0;
      pending_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
    end
  end

  // FIFO entry capture on accept
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_rd_q[wr_ptr_q]   <= lu_rd_i;
      mem_data_q[wr_ptr_q] <= lu_data_i;
    end
  end

  // Outputs are forced quiet while reset is asserted
  assign lu_ready_o = !full && !reset_i;
  assign wb_stall_o = stall && !reset_i;
  assign rf_we_o    = we && !reset_i;
  assign rf_a3_o    = reset_i ? '0 : a3;
  assign rf_wd_o    = reset_i ? '0 : wd;
  assign busy1_o    = !reset_i && (qa1_i != '0) && pending_q[qa1_i];
  assign busy2_o    = !reset_i && (qa2_i != '0) && pending_q[qa2_i];

endmodule
